seq_inst_rx: RTL and testbench

SEQ_INST_RX -- requirements
Module: seq_inst_rx

---
 rtl/seq_inst_rx.sv | 169 ++++++++++++++++
 tb/tb_seq_inst_rx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_inst_rx.sv
// rtl/seq_inst_rx.sv - byte-pair instruction assembler with in-order issue FIFO
//
// Purpose:
//   Pairs UART bytes (high byte then low byte) into IN_W-bit instructions and
//   queues them in a DEPTH-entry FIFO. The FIFO head is issued one per cycle.
//   A send instruction at the head waits while the UART transmitter is busy,
//   and everything behind it waits too, so issue order is preserved.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   i_rx_data    received byte
//   i_rx_valid   one-cycle strobe qualifying i_rx_data
//   i_tx_busy    transmitter busy, stalls a send instruction at the head
//   o_inst       instruction at FIFO head
//   o_inst_valid o_inst is issued (and popped) this cycle
//   o_count      FIFO occupancy
//   o_overflow   one-cycle pulse, assembled instruction dropped (FIFO full)
//   o_timeout    one-cycle pulse, dangling high byte discarded

module seq_inst_rx #(
  parameter int              IN_W    = 16,
  parameter int              OP_W    = 2,
  parameter logic [OP_W-1:0] OP_SEND = 2'd3,
  parameter int              DEPTH   = 4,
  parameter int              TIMEOUT = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_rx_valid,
  input  logic                     i_tx_busy,
  output logic [IN_W-1:0]          o_inst,
  output logic                     o_inst_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {
    S_HI = 1'b0,
    S_LO = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_hi;
  logic [TW-1:0]   r_tcnt;
  logic            w_load_hi;
  logic            w_push;
  logic            w_tmo;
  logic [IN_W-1:0] w_word;

  logic [IN_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_rptr;
  logic [AW-1:0]   r_wptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic            r_timeout;

  logic            w_full;
  logic            w_empty;
  logic [IN_W-1:0] w_head;
  logic            w_head_send;
  logic            w_pop;
  logic            w_accept;

  // Assembler state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_HI;
    end else begin
      r_state <= w_next;
    end
  end

  // Assembler next state; a byte in the last allowed idle cycle wins over
  // the timeout, so the instruction still completes.
  always_comb begin
    w_next    = r_state;
    w_load_hi = 1'b0;
    w_push    = 1'b0;
    w_tmo     = 1'b0;
    case (r_state)
      S_HI: begin
        if (i_rx_valid) begin
          w_load_hi = 1'b1;
          w_next    = S_LO;
        end
      end
      S_LO: begin
        if (i_rx_valid) begin
          w_push = 1'b1;
          w_next = S_HI;
        end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
          w_tmo  = 1'b1;
          w_next = S_HI;
        end
      end
      default: w_next = S_HI;
    endcase
  end

  // High byte holding register and idle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi   <= '0;
      r_tcnt <= '0;
    end else if (w_load_hi) begin
      r_hi   <= i_rx_data;
      r_tcnt <= '0;
    end else if (w_tmo) begin
      r_hi   <= '0;
      r_tcnt <= '0;
    end else if (r_state == S_LO && !i_rx_valid) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign w_word = {r_hi, i_rx_data};

  // FIFO status and issue decision
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_head      = r_mem[r_rptr];
  assign w_head_send = (w_head[IN_W-1 -: OP_W] == OP_SEND);
  assign w_pop       = ~w_empty & ~(w_head_send & i_tx_busy);
  // A full FIFO still takes the new word when the head leaves this cycle
  assign w_accept    = w_push & (~w_full | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_mem[r_wptr] <= w_word;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overflow <= w_push & ~w_accept;
      r_timeout  <= w_tmo;
    end
  end

  assign o_inst       = w_head;
  assign o_inst_valid = w_pop;
  assign o_count      = r_count;
  assign o_overflow   = r_overflow;
  assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_seq_inst_rx.sv
// tb/tb_seq_inst_rx.sv - self-checking bench for seq_inst_rx

module tb_seq_inst_rx;

  localparam int         IN_W    = 16;
  localparam int         OP_W    = 2;
  localparam logic [1:0] OP_SEND = 2'd3;
  localparam int         DEPTH   = 4;
  localparam int         TIMEOUT = 1000;
  localparam int         CW      = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            tx_busy;
  logic [IN_W-1:0] o_inst;
  logic            o_inst_valid;
  logic [CW-1:0]   o_count;
  logic            o_overflow;
  logic            o_timeout;

  always #5 clk = ~clk;

  seq_inst_rx #(
    .IN_W(IN_W), .OP_W(OP_W), .OP_SEND(OP_SEND), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_tx_busy(tx_busy), .o_inst(o_inst), .o_inst_valid(o_inst_valid),
    .o_count(o_count), .o_overflow(o_overflow), .o_timeout(o_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of pending instructions plus byte-pairing state
  logic [15:0] m_q[$];
  logic        m_hi_pend;
  logic [7:0]  m_hi;
  int          m_idle;
  logic        m_ovf;
  logic        m_to;

  function automatic logic m_valid();
    return (m_q.size() != 0) && !((m_q[0][15:14] == OP_SEND) && tx_busy);
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_hi_pend = 1'b0;
    m_hi = 8'h00;
    m_idle = 0;
    m_ovf = 1'b0;
    m_to = 1'b0;
  endtask

  task automatic model_step();
    logic        pop, push, was_full;
    logic [15:0] word;
    pop = m_valid();
    push = 1'b0;
    word = 16'h0;
    m_ovf = 1'b0;
    m_to = 1'b0;
    if (rx_valid) begin
      if (m_hi_pend) begin
        push = 1'b1;
        word = {m_hi, rx_data};
        m_hi_pend = 1'b0;
      end else begin
        m_hi = rx_data;
        m_hi_pend = 1'b1;
        m_idle = 0;
      end
    end else if (m_hi_pend) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_hi_pend = 1'b0;
        m_to = 1'b1;
      end
    end
    was_full = (m_q.size() == DEPTH);
    if (pop) m_q.delete(0);
    if (push) begin
      if (was_full && !pop) m_ovf = 1'b1;
      else m_q.push_back(word);
    end
  endtask

  // Set inputs just after a rising edge, return at the falling edge for sampling
  task automatic drive(input logic v, input logic [7:0] d, input logic b);
    rx_valid = v;
    rx_data = d;
    tx_busy = b;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rx_valid = 1'b1;
    rx_data = 8'hA5;
    tx_busy = 1'b0;
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    n_tests++; if (o_inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_inst_valid); end
    n_tests++; if (o_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", o_count); end
    n_tests++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", o_overflow); end
    n_tests++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_to: got %b want 0", o_timeout); end
    n_tests++; if (o_inst !== 16'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0000", o_inst); end
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (o_count !== '0 || o_inst !== 16'h0) begin n_fail++; $display("FAIL reset_hold: count %0d inst %h want 0 0000", o_count, o_inst); end
    rst = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic test_basic();
    drive(1, 8'h12, 0); tick();
    drive(1, 8'h34, 0);
    n_tests++; if (o_inst_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early: got %b want 0", o_inst_valid); end
    tick();
    drive(0, 8'h00, 0);
    n_tests++; if (o_inst_valid !== 1'b1 || o_inst !== 16'h1234) begin n_fail++; $display("FAIL basic_issue: valid %b inst %h want 1 1234", o_inst_valid, o_inst); end
    n_tests++; if (o_count !== CW'(1)) begin n_fail++; $display("FAIL basic_count: got %0d want 1", o_count); end
    tick();
    drive(0, 8'h00, 0);
    n_tests++; if (o_inst_valid !== 1'b0 || o_count !== '0) begin n_fail++; $display("FAIL basic_once: valid %b count %0d want 0 0", o_inst_valid, o_count); end
    tick();
  endtask

  task automatic test_send_block();
    drive(1, 8'hC0, 1); tick();
    drive(1, 8'h01, 1); tick();
    for (int i = 0; i < 10; i++) begin
      drive(i < 2, (i == 0) ? 8'h40 : 8'h05, 1);
      n_tests++; if (o_inst_valid !== 1'b0 || o_inst !== 16'hC001) begin n_fail++; $display("FAIL send_stall[%0d]: valid %b inst %h want 0 c001", i, o_inst_valid, o_inst); end
      tick();
    end
    drive(0, 8'h00, 0);
    n_tests++; if (o_count !== CW'(2)) begin n_fail++; $display("FAIL send_count: got %0d want 2", o_count); end
    n_tests++; if (o_inst_valid !== 1'b1 || o_inst !== 16'hC001) begin n_fail++; $display("FAIL send_first: valid %b inst %h want 1 c001", o_inst_valid, o_inst); end
    tick();
    drive(0, 8'h00, 0);
    n_tests++; if (o_inst_valid !== 1'b1 || o_inst !== 16'h4005) begin n_fail++; $display("FAIL send_second: valid %b inst %h want 1 4005", o_inst_valid, o_inst); end
    tick();
    drive(0, 8'h00, 0);
    n_tests++; if (o_inst_valid !== 1'b0 || o_count !== '0) begin n_fail++; $display("FAIL send_drain: valid %b count %0d want 0 0", o_inst_valid, o_count); end
    tick();
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 5; k++) begin
      drive(1, 8'hC0, 1); tick();
      drive(1, 8'(k), 1);
      n_tests++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early[%0d]: got %b want 0", k, o_overflow); end
      if (k == 4) begin
        n_tests++; if (o_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL ovf_full: got %0d want %0d", o_count, DEPTH); end
      end
      tick();
    end
    drive(0, 8'h00, 1);
    n_tests++; if (o_overflow !== 1'b1 || o_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL ovf_pulse: ovf %b count %0d want 1 %0d", o_overflow, o_count, DEPTH); end
    tick();
    drive(0, 8'h00, 1);
    n_tests++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_single: got %b want 0", o_overflow); end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 8'h00, 0);
      n_tests++; if (o_inst_valid !== 1'b1 || o_inst !== 16'hC000 + 16'(i)) begin n_fail++; $display("FAIL ovf_order[%0d]: valid %b inst %h want 1 %h", i, o_inst_valid, o_inst, 16'hC000 + 16'(i)); end
      tick();
    end
    drive(0, 8'h00, 0);
    n_tests++; if (o_inst_valid !== 1'b0 || o_count !== '0) begin n_fail++; $display("FAIL ovf_drain: valid %b count %0d want 0 0", o_inst_valid, o_count); end
    tick();
  endtask

  task automatic test_timeout();
    drive(1, 8'hAB, 0); tick();
    for (int i = 0; i < TIMEOUT; i++) begin
      drive(0, 8'h00, 0);
      if (o_timeout !== 1'b0) begin n_tests++; n_fail++; $display("FAIL to_early[%0d]: got 1 want 0", i); end
      tick();
    end
    drive(1, 8'h12, 0);
    n_tests++; if (o_timeout !== 1'b1) begin n_fail++; $display("FAIL to_pulse: got %b want 1", o_timeout); end
    n_tests++; if (o_count !== '0) begin n_fail++; $display("FAIL to_nopush: count %0d want 0", o_count); end
    tick();
    drive(1, 8'h34, 0);
    n_tests++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL to_single: got %b want 0", o_timeout); end
    tick();
    drive(0, 8'h00, 0);
    n_tests++; if (o_inst_valid !== 1'b1 || o_inst !== 16'h1234) begin n_fail++; $display("FAIL to_after: valid %b inst %h want 1 1234", o_inst_valid, o_inst); end
    tick();
    // Low byte in the last allowed idle cycle still completes the pair
    drive(1, 8'hAB, 0); tick();
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      drive(0, 8'h00, 0); tick();
    end
    drive(1, 8'hCD, 0); tick();
    drive(0, 8'h00, 0);
    n_tests++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL to_edge_pulse: got %b want 0", o_timeout); end
    n_tests++; if (o_inst_valid !== 1'b1 || o_inst !== 16'hABCD) begin n_fail++; $display("FAIL to_edge_inst: valid %b inst %h want 1 abcd", o_inst_valid, o_inst); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 8'h55, 0); tick();
    rx_valid = 1'b1;
    rx_data = 8'h99;
    rst = 1'b1;
    model_clear();
    #1;
    n_tests++; if (o_inst_valid !== 1'b0 || o_count !== '0 || o_overflow !== 1'b0 || o_timeout !== 1'b0 || o_inst !== 16'h0) begin
      n_fail++; $display("FAIL rstmid_outs: valid %b count %0d ovf %b to %b inst %h want all 0", o_inst_valid, o_count, o_overflow, o_timeout, o_inst);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 8'h12, 0); tick();
    drive(1, 8'h34, 0); tick();
    drive(0, 8'h00, 0);
    n_tests++; if (o_inst_valid !== 1'b1 || o_inst !== 16'h1234) begin n_fail++; $display("FAIL rstmid_inst: valid %b inst %h want 1 1234", o_inst_valid, o_inst); end
    tick();
  endtask

  task automatic test_full_pop();
    logic [7:0]  bytes [8];
    logic [15:0] order [4];
    bytes = '{8'hC0, 8'h01, 8'h40, 8'h11, 8'h40, 8'h12, 8'h40, 8'h13};
    order = '{16'h4011, 16'h4012, 16'h4013, 16'h4014};
    for (int i = 0; i < 8; i++) begin
      drive(1, bytes[i], 1); tick();
    end
    drive(1, 8'h40, 1);
    n_tests++; if (o_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL fp_full: got %0d want %0d", o_count, DEPTH); end
    tick();
    drive(1, 8'h14, 0);
    n_tests++; if (o_inst_valid !== 1'b1 || o_inst !== 16'hC001) begin n_fail++; $display("FAIL fp_pop: valid %b inst %h want 1 c001", o_inst_valid, o_inst); end
    tick();
    drive(0, 8'h00, 0);
    n_tests++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL fp_ovf: got %b want 0", o_overflow); end
    n_tests++; if (o_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL fp_count: got %0d want %0d", o_count, DEPTH); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) drive(0, 8'h00, 0);
      n_tests++; if (o_inst_valid !== 1'b1 || o_inst !== order[i]) begin n_fail++; $display("FAIL fp_order[%0d]: valid %b inst %h want 1 %h", i, o_inst_valid, o_inst, order[i]); end
      tick();
    end
    drive(0, 8'h00, 0);
    n_tests++; if (o_count !== '0) begin n_fail++; $display("FAIL fp_drain: got %0d want 0", o_count); end
    tick();
  endtask

  task automatic test_random();
    logic b;
    b = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(7) == 0) b = ~b;
      drive($urandom_range(1) == 1, 8'($urandom), b);
      n_tests++; if (o_inst_valid !== m_valid()) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", c, o_inst_valid, m_valid()); end
      n_tests++; if (o_count !== CW'(m_q.size())) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, o_count, m_q.size()); end
      n_tests++; if (o_overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %b want %b", c, o_overflow, m_ovf); end
      n_tests++; if (o_timeout !== m_to) begin n_fail++; $display("FAIL rnd_to@%0d: got %b want %b", c, o_timeout, m_to); end
      if (m_q.size() != 0) begin
        n_tests++; if (o_inst !== m_q[0]) begin n_fail++; $display("FAIL rnd_inst@%0d: got %h want %h", c, o_inst, m_q[0]); end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    tx_busy = 1'b0;
    model_clear();
    test_reset();
    apply_reset();
    test_basic();
    test_send_block();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_full_pop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
